// File: rtl/car_gen_pkg.sv
// car_gen_pkg: shared types and constants for the car sensor stimulus generator.
//   state_t        - sequence FSM states
//   P_NONE..P_AB   - {a,b} sensor patterns (1 = beam blocked)
//   sensor_pattern - maps a state plus the latched direction and balk flag to {a,b}
package car_gen_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_A    = 2'b10;
    localparam logic [1:0] P_B    = 2'b01;
    localparam logic [1:0] P_AB   = 2'b11;

    // An entering car blocks the outer beam first, an exiting car the inner one.
    // In PH3 a full pass leaves the far beam blocked, while a balking car backs
    // out and leaves the near beam blocked, so PH3 depends on dir XOR balk.
    function automatic logic [1:0] sensor_pattern(input state_t st,
                                                  input logic   dir_in,
                                                  input logic   balk_in);
        logic [1:0] pat;
        pat = P_NONE;
        case (st)
            PH1:     pat = dir_in ? P_A : P_B;
            PH2:     pat = P_AB;
            PH3:     pat = (dir_in ^ balk_in) ? P_B : P_A;
            default: pat = P_NONE;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that measures how long each sensor
// pattern is held.
//   clk     - system clock
//   reset   - synchronous, active-low
//   load    - reload the counter with HOLD_CYCLES-1 (phase entry)
//   en      - count down while a sequence is running
//   expired - counter is at zero; the current phase ends at this edge
module phase_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturates at zero so a stalled phase never wraps around.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/car_sensor_gen.sv
// car_sensor_gen: turns "car enters"/"car exits" commands into the timed
// two-photocell sequence a real car produces, with an optional balk (car
// backs out) for negative testing.
//   clk         - system clock
//   reset       - synchronous, active-low
//   start_enter - request an entering car (sampled in IDLE; wins over exit)
//   start_exit  - request an exiting car (sampled in IDLE)
//   balk        - sampled with the start; 1 = partial pass, car backs out
//   a, b        - outer / inner sensor, 1 = blocked
//   busy        - sequence in progress
//   done        - one-cycle pulse when a sequence finishes
//   dir         - direction of the last/current sequence, 1 = enter
//   counted     - valid with done; 1 = full pass, 0 = balk
module car_sensor_gen
    import car_gen_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_enter,
    input  logic start_exit,
    input  logic balk,
    output logic a,
    output logic b,
    output logic busy,
    output logic done,
    output logic dir,
    output logic counted
);

    state_t     state, state_next;
    logic       balk_q, balk_next;
    logic       dir_next, done_next, counted_next, busy_next;
    logic [1:0] ab_next;
    logic       load, expired;

    phase_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .en      (state != IDLE),
        .expired (expired)
    );

    // State and every output are registered so the sensor lines are glitch-free.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            balk_q  <= 1'b0;
            dir     <= 1'b0;
            done    <= 1'b0;
            counted <= 1'b0;
            busy    <= 1'b0;
            a       <= 1'b0;
            b       <= 1'b0;
        end else begin
            state   <= state_next;
            balk_q  <= balk_next;
            dir     <= dir_next;
            done    <= done_next;
            counted <= counted_next;
            busy    <= busy_next;
            {a, b}  <= ab_next;
        end
    end

    // Next-state logic. Outputs are derived from the next state so that the
    // registered pattern lines up with the registered state.
    always_comb begin
        state_next   = state;
        balk_next    = balk_q;
        dir_next     = dir;
        done_next    = 1'b0;
        counted_next = counted;
        load         = 1'b0;
        case (state)
            IDLE: begin
                if (start_enter || start_exit) begin
                    state_next = PH1;
                    dir_next   = start_enter;
                    balk_next  = balk;
                    load       = 1'b1;
                end
            end
            PH1: begin
                if (expired) begin
                    state_next = PH2;
                    load       = 1'b1;
                end
            end
            PH2: begin
                if (expired) begin
                    state_next = PH3;
                    load       = 1'b1;
                end
            end
            PH3: begin
                if (expired) begin
                    state_next = GAP;
                    load       = 1'b1;
                end
            end
            GAP: begin
                if (expired) begin
                    state_next   = IDLE;
                    done_next    = 1'b1;
                    counted_next = ~balk_q;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
        ab_next   = sensor_pattern(state_next, dir_next, balk_next);
    end

endmodule

// File: doc/car_sensor_gen.md
# car_sensor_gen

Stimulus generator for the parking-lot gate: converts "a car enters" or "a car exits" commands into timed two-sensor (a, b) photocell sequences matching what a physical car produces. It drives the sensor inputs of the gate detector in system-level simulation and in on-board demos that run without real sensors. Each command also supports a balk mode, a partial pass where the car backs out, for negative testing.

## Interface

Parameters:
- HOLD_CYCLES, default 4: clock cycles each sensor pattern is held; legal range ≥ 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low: 0 at a posedge resets the block.
- start_enter  in  1  request an entering car; sampled only in IDLE.
- start_exit  in  1  request an exiting car; sampled only in IDLE.
- balk  in  1  sampled with the start; 1 = car backs out and the pass is not completed.
- a  out  1  outer sensor, 1 = blocked.
- b  out  1  inner sensor, 1 = blocked.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-cycle pulse when a sequence finishes.
- dir  out  1  direction of the last or current sequence: 1 = enter, 0 = exit.
- counted  out  1  valid with done; 1 = full pass, 0 = balk.

## Operation

- States: IDLE, PH1, PH2, PH3, GAP. All outputs are registered.
- Sensor pattern {a,b} per state:
  - Enter, full pass: PH1 10, PH2 11, PH3 01, GAP 00.
  - Exit, full pass: PH1 01, PH2 11, PH3 10, GAP 00.
  - Enter, balk: PH1 10, PH2 11, PH3 10, GAP 00.
  - Exit, balk: PH1 01, PH2 11, PH3 01, GAP 00.
  - IDLE: {a,b} = 00.
- IDLE → PH1 when start_enter or start_exit is 1. The block latches dir, the balk flag and the pattern set at this point.
- Each phase holds for exactly HOLD_CYCLES cycles, counted by a down-counter of width $clog2(HOLD_CYCLES+1).
  - Counter loads HOLD_CYCLES−1 on phase entry.
  - Phase advances at the edge where the counter is 0.
- PH1 → PH2 → PH3 → GAP → IDLE. No other transitions.
- On GAP → IDLE, done = 1 for one cycle and counted = ~balk_latched.
- Boundary rules:
  - start_enter and start_exit both high in IDLE: enter wins.
  - Any start while busy is ignored. It is not queued.
  - Start held high continuously: a new sequence begins in the cycle after done, so consecutive cars are separated by the HOLD_CYCLES-long GAP plus one IDLE cycle.
  - Reset mid-sequence: next cycle gives IDLE, {a,b}=00, busy=0, done=0. No done pulse is emitted for the aborted sequence.
  - HOLD_CYCLES=1: each pattern lasts one cycle. No counter wrap occurs.

## Timing

- Reset values: a=0, b=0, busy=0, done=0, dir=0, counted=0, state IDLE, counter 0.
- Start sampled high at edge k (IDLE):
  - Cycles k+1 … k+H: PH1 pattern, busy=1.
  - k+H+1 … k+2H: PH2.
  - k+2H+1 … k+3H: PH3.
  - k+3H+1 … k+4H: GAP (00, busy=1).
  - k+4H+1: IDLE, busy=0, done=1.
- Total busy time is 4·HOLD_CYCLES cycles. Start-to-first-pattern latency is one cycle.
- Only one of a, b changes per pattern transition. There are no glitches: outputs come straight from flops.
- dir is updated at edge k and holds until the next accepted start. counted is updated with done and holds until the next done.

## Structure

- Package car_gen_pkg holds:
  - The state enum (IDLE, PH1, PH2, PH3, GAP).
  - Pattern constants: P_NONE=2'b00, P_A=2'b10, P_B=2'b01, P_AB=2'b11.
- One sub-module, phase_timer: loadable down-counter parameterised by HOLD_CYCLES, with inputs load and en and output expired.
- The top level holds the FSM and the pattern mux.

## Test plan

All scenarios use HOLD_CYCLES=4.
- Reset, then idle for 5 cycles → a=b=0, busy=0, done=0 throughout.
- start_enter pulsed at edge 0 → {a,b}=10 in cycles 1–4, 11 in 5–8, 01 in 9–12, 00 in 13–16. busy=1 in cycles 1–16. Cycle 17: done=1, dir=1, counted=1.
- start_exit with balk=1 → {a,b}=01, 11, 01, 00, 4 cycles each. done at cycle 17 with dir=0, counted=0.
- start_enter and start_exit high together, then start_exit pulsed at cycle 6 → enter sequence only, exit ignored. Exactly one done pulse.
- reset=0 at cycle 7 of an enter sequence → cycle 8: {a,b}=00, busy=0, no done. A new start_exit then produces a clean exit sequence.
- Chain with the gate detector: one enter sequence then one exit sequence → detector emits exactly one enter pulse and one exit pulse. A balked enter → no pulse.
